// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, sequencer states and constants for the ALU operand sequencer
package alu_pkg;
  localparam int NREGS = 4;
  localparam logic [3:0] OP_INC = 4'b1000;
  localparam logic [3:0] OP_DEC = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_5 = 4'b0101;
  localparam logic [7:0] INST_NOP = 8'h00;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
endpackage

// File: rtl/alu_op_regfile.sv
// alu_op_regfile: 4x8 register file with two operand read ports, a host read port and a writeback-over-host write
module alu_op_regfile
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wb_we,
  input  logic [1:0] i_wb_addr,
  input  logic [7:0] i_wb_data,
  input  logic       i_host_we,
  input  logic [1:0] i_host_addr,
  input  logic [7:0] i_host_data,
  input  logic [1:0] i_ra_addr,
  input  logic [1:0] i_rb_addr,
  input  logic [1:0] i_host_raddr,
  output logic [7:0] o_ra,
  output logic [7:0] o_rb,
  output logic [7:0] o_host_rdata
);
  logic [7:0] r_regs [NREGS];
  assign o_ra = r_regs[i_ra_addr];
  assign o_rb = r_regs[i_rb_addr];
  assign o_host_rdata = r_regs[i_host_raddr];
  // per-register write: writeback wins a same-index collision, different indices both land
  always_ff @(posedge clk) begin
    if (!rst_n) r_regs <= '{default: '0};
    else
      for (int i = 0; i < NREGS; i++)
        if (i_wb_we && i_wb_addr == 2'(i)) r_regs[i] <= i_wb_data;
        else if (i_host_we && i_host_addr == 2'(i)) r_regs[i] <= i_host_data;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU command at a time, drives operands, waits out ALU latency, writes result back
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_dst,
  input  logic [1:0] cmd_srca,
  input  logic [1:0] cmd_srcb,
  output logic [7:0] alu_ra,
  output logic [7:0] alu_rb,
  output logic [7:0] alu_inst,
  input  logic [7:0] alu_rd,
  input  logic [7:0] alu_flags,
  input  logic       host_we,
  input  logic [1:0] host_waddr,
  input  logic [7:0] host_wdata,
  input  logic [1:0] host_raddr,
  output logic [7:0] host_rdata,
  output logic       done,
  output logic [7:0] flags_q
);
  state_t r_state, w_next;
  logic [1:0] r_dst;
  logic [2:0] r_cnt;
  logic [7:0] w_ra, w_rb;
  logic w_accept;
  assign cmd_ready = r_state == IDLE;
  assign w_accept = cmd_valid && cmd_ready;
  alu_op_regfile u_regs (
    .clk(clk),
    .rst_n(rst_n),
    .i_wb_we(r_state == WB),
    .i_wb_addr(r_dst),
    .i_wb_data(alu_rd),
    .i_host_we(host_we),
    .i_host_addr(host_waddr),
    .i_host_data(host_wdata),
    .i_ra_addr(cmd_srca),
    .i_rb_addr(cmd_srcb),
    .i_host_raddr(host_raddr),
    .o_ra(w_ra),
    .o_rb(w_rb),
    .o_host_rdata(host_rdata)
  );
  // next state: WAIT spans ALU_LATENCY-1 cycles so the ALU sees ALU_LATENCY+1 stable cycles
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_accept ? ISSUE : IDLE;
      ISSUE: w_next = ALU_LATENCY == 1 ? WB : WAIT;
      WAIT:  w_next = r_cnt == 3'd1 ? WB : WAIT;
      WB:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state, latency counter, ALU input registers, done pulse and flag capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dst <= '0;
      r_cnt <= '0;
      alu_ra <= '0;
      alu_rb <= '0;
      alu_inst <= INST_NOP;
      done <= 1'b0;
      flags_q <= '0;
    end else begin
      r_state <= w_next;
      done <= r_state == WB;
      if (r_state == ISSUE) r_cnt <= 3'(ALU_LATENCY - 1);
      else if (r_state == WAIT) r_cnt <= r_cnt - 3'd1;
      if (w_accept) begin
        r_dst <= cmd_dst;
        alu_ra <= w_ra;
        alu_rb <= w_rb;
        alu_inst <= {cmd_op, 4'h0};
      end else if (r_state == WB) begin
        alu_ra <= '0;
        alu_rb <= '0;
        alu_inst <= INST_NOP;
        flags_q <= alu_flags;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scenario tests of the ALU operand sequencer with a behavioural ALU
module tb_alu_op_sequencer;
  import alu_pkg::*;
  localparam int L = 3;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [3:0] cmd_op = 0;
  logic [1:0] cmd_dst = 0, cmd_srca = 0, cmd_srcb = 0;
  logic [7:0] alu_ra, alu_rb, alu_inst, alu_rd, alu_flags;
  logic host_we = 0;
  logic [1:0] host_waddr = 0, host_raddr = 0;
  logic [7:0] host_wdata = 0, host_rdata, flags_q;
  logic done;
  int n_checks = 0, n_fail = 0;

  alu_op_sequencer #(.ALU_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_inst(alu_inst), .alu_rd(alu_rd), .alu_flags(alu_flags),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .host_raddr(host_raddr), .host_rdata(host_rdata), .done(done), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_rd = alu_ra & alu_rb;
    case (alu_inst[7:4])
      OP_INC: alu_rd = alu_ra + 8'd1;
      OP_DEC: alu_rd = alu_ra - 8'd1;
      OP_ADD: alu_rd = alu_ra + alu_rb;
      OP_SUB: alu_rd = alu_ra - alu_rb;
      default: alu_rd = alu_ra & alu_rb;
    endcase
    alu_flags = {4'hA, alu_rd[7], alu_rd == 8'h00, 2'b10};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    host_we = 1; host_waddr = a; host_wdata = d;
    step();
    host_we = 0;
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa, input logic [1:0] sb);
    cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb; cmd_valid = 1;
    step();
    cmd_valid = 0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] v);
    host_raddr = a;
    #1;
    v = host_rdata;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!done && n < 20) begin step(); n++; end
    ok = done;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 0; step(); step(); rst_n = 1;
    host_wr(1, 8'h33); host_wr(0, 8'h11);
    send(OP_ADD, 2, 0, 1);
    rst_n = 0; repeat (3) step(); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 00", i, v); end
    end
    n_checks++; if (alu_inst !== 8'h00) begin n_fail++; $display("FAIL reset_inst: got %h expected 00", alu_inst); end
    n_checks++; if (alu_ra !== 8'h00 || alu_rb !== 8'h00) begin n_fail++; $display("FAIL reset_operands: got %h/%h expected 00/00", alu_ra, alu_rb); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (flags_q !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %h expected 00", flags_q); end
  endtask

  task automatic test_add();
    logic [7:0] v;
    int bad = 0;
    host_wr(0, 8'h0B); host_wr(1, 8'h02);
    send(OP_ADD, 2, 0, 1);
    n_checks++; if (alu_ra !== 8'h0B || alu_rb !== 8'h02) begin n_fail++; $display("FAIL add_operands: got %h/%h expected 0b/02", alu_ra, alu_rb); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy_ready: got %b expected 0", cmd_ready); end
    for (int k = 1; k <= L + 1; k++) begin
      if (alu_inst !== 8'hA0 || done !== 1'b0) bad++;
      step();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL add_inst_hold: got %0d bad cycles expected 0", bad); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done_timing: got %b expected 1", done); end
    n_checks++; if (alu_inst !== 8'h00) begin n_fail++; $display("FAIL add_inst_clear: got %h expected 00", alu_inst); end
    read_reg(2, v);
    n_checks++; if (v !== 8'h0D) begin n_fail++; $display("FAIL add_result: got %h expected 0d", v); end
    n_checks++; if (flags_q !== 8'hA2) begin n_fail++; $display("FAIL add_flags: got %h expected a2", flags_q); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_inc();
    logic [7:0] v;
    host_wr(0, 8'h7F);
    send(OP_INC, 0, 0, 0);
    repeat (L) step();
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL inc_wb_ready: got %b expected 0", cmd_ready); end
    step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL inc_done: got %b expected 1", done); end
    read_reg(0, v);
    n_checks++; if (v !== 8'h80) begin n_fail++; $display("FAIL inc_result: got %h expected 80", v); end
    n_checks++; if (flags_q !== 8'hAA) begin n_fail++; $display("FAIL inc_flags: got %h expected aa", flags_q); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    bit ok;
    int n = 0;
    host_wr(0, 8'h0F); host_wr(1, 8'h05);
    cmd_op = OP_SUB; cmd_dst = 3; cmd_srca = 0; cmd_srcb = 1; cmd_valid = 1;
    step();
    cmd_op = OP_DEC; cmd_dst = 3; cmd_srca = 3; cmd_srcb = 3;
    while (!cmd_ready && n < 20) begin step(); n++; end
    step(); n++;
    cmd_valid = 0;
    n_checks++; if (n != L + 2) begin n_fail++; $display("FAIL b2b_interval: got %0d expected %0d", n, L + 2); end
    n_checks++; if (alu_inst !== 8'h90 || alu_ra !== 8'h0A) begin n_fail++; $display("FAIL b2b_second_issue: got %h/%h expected 90/0a", alu_inst, alu_ra); end
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_done_timeout: got 0 expected 1"); end
    read_reg(3, v);
    n_checks++; if (v !== 8'h09) begin n_fail++; $display("FAIL b2b_result: got %h expected 09", v); end
  endtask

  task automatic test_collision();
    logic [7:0] v;
    host_wr(0, 8'h03); host_wr(1, 8'h04);
    send(OP_ADD, 2, 0, 1);
    repeat (L) step();
    host_wr(2, 8'h55);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL coll_align: got %b expected 1", done); end
    read_reg(2, v);
    n_checks++; if (v !== 8'h07) begin n_fail++; $display("FAIL coll_same_idx: got %h expected 07", v); end
    send(OP_ADD, 2, 0, 1);
    repeat (L) step();
    host_wr(1, 8'h55);
    read_reg(2, v);
    n_checks++; if (v !== 8'h07) begin n_fail++; $display("FAIL coll_diff_wb: got %h expected 07", v); end
    read_reg(1, v);
    n_checks++; if (v !== 8'h55) begin n_fail++; $display("FAIL coll_diff_host: got %h expected 55", v); end
  endtask

  task automatic test_abort();
    logic [7:0] v;
    bit ok, saw = 0;
    rst_n = 0; step(); rst_n = 1;
    host_wr(0, 8'h0B); host_wr(1, 8'h02);
    send(OP_ADD, 3, 0, 1);
    step();
    rst_n = 0; step(); rst_n = 1;
    repeat (L + 3) begin
      if (done) saw = 1;
      step();
    end
    n_checks++; if (saw) begin n_fail++; $display("FAIL abort_done: got 1 expected 0"); end
    read_reg(3, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL abort_dst: got %h expected 00", v); end
    host_wr(0, 8'h0B); host_wr(1, 8'h02);
    send(OP_5, 3, 0, 1);
    n_checks++; if (alu_inst !== 8'h50) begin n_fail++; $display("FAIL abort_op5_inst: got %h expected 50", alu_inst); end
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_op5_timeout: got 0 expected 1"); end
    read_reg(3, v);
    n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL abort_op5_result: got %h expected 02", v); end
    n_checks++; if (flags_q !== 8'hA2) begin n_fail++; $display("FAIL abort_op5_flags: got %h expected a2", flags_q); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_inc();
    test_back_to_back();
    test_collision();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
